// File: rtl/io_hex_display.sv
// Hex viewer for the 16-bit ioOutput bus: a 4-digit common-anode 7-segment display, one digit
// per REFRESH_DIV clocks. Optional macro LEADING_ZERO_BLANK_EN blanks the leading zero digits.
module io_hex_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] ioOutput,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        changed
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_changed;

  logic [PW-1:0] w_presc_nxt;
  logic [1:0]    w_idx_nxt;
  logic [15:0]   w_shadow_nxt;
  logic          w_changed_nxt;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_an_nxt;
  logic          w_tick;
  logic          w_capture;
  logic [3:0]    w_nibble;
  logic          w_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      default: pat = 7'b0001110;
    endcase
    return pat;
  endfunction

  assign w_tick    = (r_presc == PrescMax);
  // Shadow only moves on the scan wrap so one frame always shows a single value.
  assign w_capture = w_tick && (r_idx == 2'd3);

  always_comb begin
    w_presc_nxt   = w_tick ? '0 : r_presc + 1'b1;
    w_idx_nxt     = w_tick ? r_idx + 2'd1 : r_idx;
    w_shadow_nxt  = w_capture ? ioOutput : r_shadow;
    w_changed_nxt = w_capture && (ioOutput != r_shadow);
  end

  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd0:    w_nibble = r_shadow[3:0];
      2'd1:    w_nibble = r_shadow[7:4];
      2'd2:    w_nibble = r_shadow[11:8];
      default: w_nibble = r_shadow[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_shadow[15:4] == 12'h000);
      2'd2:    w_blank = (r_shadow[15:8] == 8'h00);
      2'd3:    w_blank = (r_shadow[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = ~(4'b0001 << r_idx);
    w_seg_nxt = w_blank ? 7'b1111111 : hex_to_seg(w_nibble);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_presc   <= '0;
      r_idx     <= 2'd0;
      r_shadow  <= 16'h0000;
      r_changed <= 1'b0;
      r_an      <= 4'b1111;
      r_seg     <= 7'b1111111;
    end else begin
      r_presc   <= w_presc_nxt;
      r_idx     <= w_idx_nxt;
      r_shadow  <= w_shadow_nxt;
      r_changed <= w_changed_nxt;
      r_an      <= w_an_nxt;
      r_seg     <= w_seg_nxt;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign dp      = 1'b1;
  assign changed = r_changed;

endmodule

// File: tb/tb_io_hex_display.sv
// Directed bench for io_hex_display at REFRESH_DIV=4: reset, capture, mid-frame change,
// repeat capture, reset on the wrap tick and leading-zero display.
module tb_io_hex_display;

  logic        CLK;
  logic        reset;
  logic [15:0] ioOutput;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        changed;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  logic [6:0]  hex_seg [16];

  io_hex_display #(
    .REFRESH_DIV(4)
  ) u_dut (
    .CLK     (CLK),
    .reset   (reset),
    .ioOutput(ioOutput),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .changed (changed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] val, input int d);
    logic [15:0] upper;
    upper = val >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0000) return 7'b1111111;
`endif
    return hex_seg[upper[3:0]];
  endfunction

  // n cycles of digit d of val; changed expected high only on the last when chg_last is set
  task automatic show_digit(input logic [15:0] val, input int d, input int n, input logic chg_last);
    logic [3:0] an_e;
    an_e = ~(4'b0001 << d);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      check_val("an", {12'h0, an}, {12'h0, an_e});
      check_val("seg", {9'h0, seg}, {9'h0, exp_seg(val, d)});
      check_val("changed", {15'h0, changed}, {15'h0, chg_last && (i == n - 1)});
    end
  endtask

  task automatic frame(input logic [15:0] val, input logic chg_last);
    for (int d = 0; d < 4; d++) show_digit(val, d, 4, chg_last && (d == 3));
  endtask

  initial begin
    hex_seg[0]  = 7'b1000000; hex_seg[1]  = 7'b1111001;
    hex_seg[2]  = 7'b0100100; hex_seg[3]  = 7'b0110000;
    hex_seg[4]  = 7'b0011001; hex_seg[5]  = 7'b0010010;
    hex_seg[6]  = 7'b0000010; hex_seg[7]  = 7'b1111000;
    hex_seg[8]  = 7'b0000000; hex_seg[9]  = 7'b0010000;
    hex_seg[10] = 7'b0001000; hex_seg[11] = 7'b0000011;
    hex_seg[12] = 7'b1000110; hex_seg[13] = 7'b0100001;
    hex_seg[14] = 7'b0000110; hex_seg[15] = 7'b0001110;
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    reset = 1'b1;
    ioOutput = 16'h1234;

    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_an", {12'h0, an}, 16'h000F);
    check_val("rst_seg", {9'h0, seg}, 16'h007F);
    check_val("rst_dp", {15'h0, dp}, 16'h0001);
    check_val("rst_changed", {15'h0, changed}, 16'h0000);

    // First post-reset frame shows 0000; capture of 1234 pulses changed on cycle 17
    reset = 1'b0;
    cyc = 1;
    frame(16'h0000, 1'b1);
    frame(16'h1234, 1'b0);

    // ABCD arrives during digit 1; display holds 1234 until the wrap
    show_digit(16'h1234, 0, 4, 1'b0);
    ioOutput = 16'hABCD;
    show_digit(16'h1234, 1, 4, 1'b0);
    show_digit(16'h1234, 2, 4, 1'b0);
    show_digit(16'h1234, 3, 4, 1'b1);

    // Identical value captured at each following wrap: no pulse
    frame(16'hABCD, 1'b0);
    frame(16'hABCD, 1'b0);
    frame(16'hABCD, 1'b0);

    // Reset lands on the index-3 tick with FFFF on the bus
    ioOutput = 16'hFFFF;
    show_digit(16'hABCD, 0, 4, 1'b0);
    show_digit(16'hABCD, 1, 4, 1'b0);
    show_digit(16'hABCD, 2, 4, 1'b0);
    show_digit(16'hABCD, 3, 3, 1'b0);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    cyc++;
    check_val("midrst_an", {12'h0, an}, 16'h000F);
    check_val("midrst_seg", {9'h0, seg}, 16'h007F);
    check_val("midrst_changed", {15'h0, changed}, 16'h0000);
    reset = 1'b0;
    ioOutput = 16'h0005;
    cyc = 0;
    frame(16'h0000, 1'b1);
    frame(16'h0005, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
